alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 4-bit ALU datapath among `NUM_REQ` requesters. Each requester presents an operation over a valid/ready handshake. The block grants one request per cycle, executes it on the shared ALU, and returns a registered result with flags and the requester ID on a single valid/ready response channel. It sits between the requesting control units and the 4-bit ALU.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: requester ID width, equal to clog2(`NUM_REQ`).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high.
- `req_a` in 4*`NUM_REQ`: operand A; requester i uses bits [4i+3:4i].
- `req_b` in 4*`NUM_REQ`: operand B, packed the same way.
- `req_sel` in 3*`NUM_REQ`: ALU select; requester i uses bits [3i+2:3i].
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: requester that issued the operation.
- `rsp_result` out 4: ALU result.
- `rsp_zero` out 1: result == 0.
- `rsp_carry` out 1: carry for ADD, borrow for SUB, 0 otherwise.
- `rsp_overflow` out 1: two's-complement overflow for ADD/SUB, 0 otherwise.
- `ops_done` out 16: count of completed responses (handshakes on the response channel).

## Operation
ALU ops (`sel`):
- 000: ADD, a+b.
- 001: SUB, a−b.
- 010: AND.
- 011: OR.
- 100: NOT a.
- 101: XOR.
- 110, 111: result 0, carry 0, overflow 0.

Arithmetic and flags:
- Internal sum/difference is 5 bits wide. Result is bits [3:0].
- ADD carry = bit 4 of the sum. SUB carry = borrow (a < b unsigned).
- ADD overflow = a[3]==b[3] && res[3]!=a[3].
- SUB overflow = a[3]!=b[3] && res[3]!=a[3].

FSM states:
- EMPTY: no result held. `rsp_valid`=0.
- FULL: result register valid. `rsp_valid`=1.

Accept condition:
- `can_accept` = (state==EMPTY) || (`rsp_ready` && state==FULL).
- When `can_accept` and any `req_valid` is high, the winner's `req_ready`=1 combinationally. Its operands go through the ALU and are captured in the result register with the winner's ID. Next state is FULL.

Transitions:
- EMPTY → FULL: accept.
- FULL → FULL: response drained and a new request accepted in the same cycle, or response not drained. Result register is held stable while not drained.
- FULL → EMPTY: response drained and no request.

Arbitration:
- Round-robin. Search starts at `last_grant`+1 and wraps modulo `NUM_REQ`.
- `last_grant` updates only on an accepted request.
- Requests not granted stay pending. The requester must hold valid and payload until ready; no drop.
- `req_ready` is all 0 when `can_accept`=0.

Counter:
- `ops_done` increments on `rsp_valid && rsp_ready` and wraps at 0xFFFF → 0.

## Timing
- Latency: request accepted in cycle N → response visible in cycle N+1.
- Throughput: 1 op/cycle while `rsp_ready`=1.
- Reset values: state EMPTY, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, all flags 0, `ops_done`=0, `last_grant`=`NUM_REQ`−1 (requester 0 has first priority), `req_ready`=0 during reset.
- Reset mid-operation: a held response is discarded and pending requests are not accepted. Requests are re-arbitrated from requester 0 after reset deasserts.
- Backpressure: while `rsp_ready`=0 in FULL, all `rsp_*` outputs are stable and no request is accepted.
- `req_ready` depends combinationally on `req_valid`, `rsp_ready` and state. There is no combinational path from `req_*` payload to `rsp_*`.

## Structure
- Shared package `alu_pkg`: select encodings (`ALU_ADD`…`ALU_XOR`), `ALU_W`=4, `SEL_W`=3, and a flags struct {zero, carry, overflow}.
- Sub-module `alu_core`: purely combinational 4-bit ALU computing result and the three flags per the rules above.
- Round-robin pick as a function inside the arbiter.

## Test plan
- Single request: after reset, requester 0 sends ADD a=7, b=9. Next cycle: `rsp_valid`=1, id=0, result=0, zero=1, carry=1, overflow=0.
- Signed overflow: SUB a=8, b=1 → result=7, carry=0, overflow=1. ADD a=5, b=3 → result=8, overflow=1, carry=0.
- Fairness: all 4 requesters hold valid with `rsp_ready`=1. Grants go 0,1,2,3,0,… one per cycle, and `ops_done` counts 1,2,3,…
- Backpressure: hold `rsp_ready`=0 for 3 cycles with requesters 1 and 2 valid. Result and ID stay stable and `req_ready` stays 0. After release, requester 1 then 2 are served back-to-back.
- Unused select: sel=110, a=F, b=F → result=0, zero=1, carry=0, overflow=0. NOT a=5 → A.
- Reset mid-operation: assert `rst` while FULL with requester 3 pending. Next cycle `rsp_valid`=0 and `ops_done`=0. The first grant after reset goes to the lowest valid index.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: select encodings, widths,
// the flag bundle and the response-holding FSM states.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOT = 3'b100,
    ALU_XOR = 3'b101
  } alu_sel_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

  // EMPTY: no result held; FULL: result register presented on rsp_*.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU. Carry means carry-out for ADD and
// borrow for SUB; overflow is two's-complement overflow for ADD/SUB only.
// Selects 110/111 produce an all-zero result with zero=1.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [ALU_W-1:0] result,
  output alu_flags_t       flags
);

  logic [ALU_W:0] sum;
  logic [ALU_W:0] diff;

  // Evaluate the selected operation and derive flags from the 5-bit intermediates.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    flags  = '0;
    case (alu_sel_e'(sel))
      ALU_ADD: begin
        result         = sum[ALU_W-1:0];
        flags.carry    = sum[ALU_W];
        flags.overflow = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SUB: begin
        result         = diff[ALU_W-1:0];
        flags.carry    = diff[ALU_W];
        flags.overflow = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOT: result = ~a;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU among NUM_REQ requesters.
// One request is granted per cycle; its result is registered and offered
// on a single response channel one cycle after acceptance.
//
// Handshake: a transfer happens on a channel in any cycle where valid and
// ready are both high at the rising edge. A requester holds req_valid and
// its payload stable until it sees its req_ready bit; the response holds
// rsp_* stable until rsp_ready is seen with rsp_valid. req_ready depends
// combinationally on req_valid, rsp_ready and state, never on payload.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [ALU_W*NUM_REQ-1:0] req_a,
  input  logic [ALU_W*NUM_REQ-1:0] req_b,
  input  logic [SEL_W*NUM_REQ-1:0] req_sel,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [ALU_W-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  output logic [15:0]              ops_done
);

  rsp_state_e       state;
  rsp_state_e       state_next;
  logic             can_accept;
  logic [ID_W:0]    pick;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  last_grant;
  logic [ALU_W-1:0] a_arr   [NUM_REQ];
  logic [ALU_W-1:0] b_arr   [NUM_REQ];
  logic [SEL_W-1:0] sel_arr [NUM_REQ];
  logic [ALU_W-1:0] alu_result;
  alu_flags_t       alu_flags;

  // Returns {found, index}: first valid requester after 'last', wrapping.
  // Scans farthest-first so the nearest candidate is the one left standing.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] found;
    int            idx;
    found = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[ID_W'(idx)]) found = {1'b1, ID_W'(idx)};
    end
    return found;
  endfunction

  // Unpack the per-requester operand buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i]   = req_a[i*ALU_W +: ALU_W];
      b_arr[i]   = req_b[i*ALU_W +: ALU_W];
      sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
    end
  end

  // Arbitration, req_ready generation and next-state logic.
  always_comb begin
    can_accept  = (state == ST_EMPTY) || (rsp_ready && (state == ST_FULL));
    pick        = rr_pick(req_valid, last_grant);
    grant_id    = pick[ID_W-1:0];
    grant_valid = can_accept && pick[ID_W] && !rst;
    req_ready   = '0;
    state_next  = state;
    if (grant_valid) begin
      req_ready[grant_id] = 1'b1;
      state_next          = ST_FULL;
    end else if ((state == ST_FULL) && rsp_ready) begin
      state_next = ST_EMPTY;
    end
  end

  alu_core u_alu_core (
    .a      (a_arr[grant_id]),
    .b      (b_arr[grant_id]),
    .sel    (sel_arr[grant_id]),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  // Result register and round-robin pointer, loaded only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      last_grant   <= ID_W'(NUM_REQ - 1);
    end else if (grant_valid) begin
      rsp_id       <= grant_id;
      rsp_result   <= alu_result;
      rsp_zero     <= alu_flags.zero;
      rsp_carry    <= alu_flags.carry;
      rsp_overflow <= alu_flags.overflow;
      last_grant   <= grant_id;
    end
  end

  // Count response-channel handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)                          ops_done <= '0;
    else if (rsp_valid && rsp_ready)  ops_done <= ops_done + 16'd1;
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random traffic,
// all checked against an arithmetic reference model and a response queue.
module tb_alu_share_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [3*N-1:0] req_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [3:0]    rsp_result;
  logic          rsp_zero;
  logic          rsp_carry;
  logic          rsp_overflow;
  logic [15:0]   ops_done;

  logic [3:0] a_arr [N];
  logic [3:0] b_arr [N];
  logic [2:0] s_arr [N];

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] m_ops;
  int          m_last;
  logic [N-1:0] last_rdy;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sel      (req_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .ops_done     (ops_done)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester payload arrays onto the DUT buses.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*4 +: 4]   = a_arr[i];
      req_b[i*4 +: 4]   = b_arr[i];
      req_sel[i*3 +: 3] = s_arr[i];
    end
  end

  // Reference ALU from signed/unsigned integer arithmetic: {res, zero, carry, ovf}.
  function automatic logic [6:0] alu_model(input int a, input int b, input int sel);
    int r, c, v, sa, sb, ss;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r = 0; c = 0; v = 0;
    case (sel)
      0: begin r = (a + b) % 16; c = (a + b > 15); ss = sa + sb; v = (ss > 7 || ss < -8); end
      1: begin r = (a - b + 16) % 16; c = (a < b); ss = sa - sb; v = (ss > 7 || ss < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = 15 - a;
      5: r = a ^ b;
      default: r = 0;
    endcase
    return {r[3:0], (r == 0), c[0], v[0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    w = -1;
    exp_rdy = '0;
    if (!rst && (exp_q.size() == 0 || rsp_ready)) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 16'(req_ready), 16'(exp_rdy));
    check("rsp_valid", 16'(rsp_valid), 16'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("rsp_payload", 16'({rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 16'(exp_q[0]));
    check("ops_done", ops_done, m_ops);
    last_rdy = exp_rdy;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_ops  = '0;
      m_last = N - 1;
    end else begin
      if (exp_q.size() != 0 && rsp_ready) begin
        void'(exp_q.pop_front());
        m_ops = m_ops + 16'd1;
      end
      if (w >= 0) begin
        exp_q.push_back({w[1:0], alu_model(int'(a_arr[w]), int'(b_arr[w]), int'(s_arr[w]))});
        m_last = w;
      end
    end
    #1;
  endtask

  task automatic send(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    req_valid[idx] = 1'b1;
    a_arr[idx] = a;
    b_arr[idx] = b;
    s_arr[idx] = s;
  endtask

  task automatic single(input string tag, input int idx, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] s, input logic [6:0] exp_flags);
    send(idx, a, b, s);
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    check({tag, "_valid"}, 16'(rsp_valid), 16'd1);
    check({tag, "_id"}, 16'(rsp_id), 16'(idx));
    check({tag, "_res_flags"}, 16'({rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 16'(exp_flags));
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    m_ops = '0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; s_arr[i] = '0; end
    send(0, 4'h1, 4'h1, 3'd0);
    rsp_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    check("reset_outputs", 16'({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 16'd0);
    check("reset_ops", ops_done, 16'd0);

    // Single request, held without drain for one cycle.
    send(0, 4'd7, 4'd9, 3'd0);
    cycle();
    req_valid = '0;
    check("add79_id", 16'(rsp_id), 16'd0);
    check("add79", 16'({rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 16'b1_0000_1_1_0);
    rsp_ready = 1'b1;
    cycle();

    // Flag corner cases: {res, zero, carry, overflow}.
    single("sub81", 1, 4'd8, 4'd1, 3'd1, 7'b0111_0_0_1);
    single("add53", 2, 4'd5, 4'd3, 3'd0, 7'b1000_0_0_1);
    single("sel6",  3, 4'hF, 4'hF, 3'd6, 7'b0000_1_0_0);
    single("not5",  0, 4'd5, 4'd0, 3'd4, 7'b1010_0_0_0);
    single("sub_borrow", 1, 4'd2, 4'd5, 3'd1, 7'b1101_0_1_0);

    // Fairness from a clean reset: grants 0,1,2,3,0,...
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) send(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("fair_id", 16'(rsp_id), 16'(k % N));
      check("fair_ops", ops_done, 16'(k));
    end

    // Backpressure: response from requester 3 must be held; 1 and 2 wait.
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_id", 16'(rsp_id), 16'd3);
      check("bp_ready", 16'(req_ready), 16'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_first", 16'(rsp_id), 16'd1);
    req_valid[1] = 1'b0;
    cycle();
    check("bp_second", 16'(rsp_id), 16'd2);
    req_valid = '0;
    cycle();

    // Reset while FULL with requester 3 pending.
    send(0, 4'd1, 4'd2, 3'd0);
    rsp_ready = 1'b0;
    cycle();
    req_valid = 4'b1010;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_valid", 16'(rsp_valid), 16'd0);
    check("rst_mid_ops", ops_done, 16'd0);
    rsp_ready = 1'b1;
    cycle();
    check("rst_first_grant", 16'(rsp_id), 16'd1);
    req_valid[1] = 1'b0;

    // Random traffic; requesters hold payload until accepted.
    for (int t = 0; t < 400; t++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (last_rdy[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          a_arr[i] = 4'($urandom);
          b_arr[i] = 4'($urandom);
          s_arr[i] = 3'($urandom);
        end
      end
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
